i2s_clock_gen: RTL and testbench
================================

# i2s_clock_gen

Parametrised I2S/left-justified bit-clock and frame-clock generator, replacing the fixed free-running dividers in the audio top level. It derives BCLK and LRCLK from the system clock with configurable slot width, channel count and framing mode. It provides start/stop control with clean frame-boundary stopping and exports single-cycle strobes and slot indices so serialisers and deserialisers run in the `clk` domain without using BCLK as a clock.

## Interface
- `HALF_DIV`, 2: `clk` cycles per BCLK half-period; ≥1.
- `BITS`, 24: bits per channel slot; ≥2.
- `CHANNELS`, 2: slots per frame; even, ≥2.
- `MODE`, 0: 0 = I2S (LRCLK leads MSB by one BCLK), 1 = left-justified.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run request, level-sensitive.
- `bclk` out 1: bit clock; register output.
- `lrclk` out 1: frame/word select. 0 for channels 0..CHANNELS/2-1, 1 for the rest.
- `bit_strobe` out 1: one-`clk` pulse when the next serial bit is launched.
- `bclk_rise` out 1: one-`clk` pulse in the cycle `bclk` becomes 1; this is the sample point.
- `frame_start` out 1: pulse coincident with the `bit_strobe` that launches channel 0's MSB.
- `bit_idx` out max(1,clog2(BITS)): index of the bit launched at the current/last `bit_strobe`; MSB first.
- `ch_idx` out max(1,clog2(CHANNELS)): channel of that bit.
- `busy` out 1: high while in RUN.

## Operation
- States:
  - IDLE: `bclk`=0, `lrclk`=0, no strobes.
  - RUN: the divider counter `cnt` counts 0..HALF_DIV-1. In the cycle after `cnt`=HALF_DIV-1, `bclk` toggles and `cnt` returns to 0.
- IDLE→RUN: `en`=1 sampled in IDLE. In the next cycle:
  - `busy`=1, `bit_strobe`=1, `frame_start`=1.
  - `bit_idx`=BITS-1, `ch_idx`=0, `bclk`=0, `cnt`=0.
- Each `bclk` 1→0 transition in RUN is a fall. On each fall:
  - `bit_strobe`=1.
  - `bit_idx` decrements.
  - When `bit_idx` is 0, `bit_idx` wraps to BITS-1 and `ch_idx` increments, wrapping to 0.
  - `frame_start`=1 when the new position is ch 0 / MSB.
- `lrclk` updates only on `bit_strobe` cycles:
  - MODE=1: `lrclk` = (new `ch_idx` ≥ CHANNELS/2).
  - MODE=0: `lrclk` takes the half-value of the channel that follows. The change happens on the strobe launching `bit_idx`=0, i.e. one BCLK before the next MSB.
- Stop:
  - `en`=0 is acted on only at the fall that would start a new frame.
  - In that cycle: `bclk`=0 (a fall), no `bit_strobe` or `frame_start`, state IDLE, `busy`=0.
  - `bit_idx`=BITS-1, `ch_idx`=0, `lrclk`=0.
  - `en` is sampled at that fall: if 1, the frame continues with no gap.
- A deassertion of `en` mid-frame that is reasserted before the frame boundary has no effect.
- `rst`: in the next cycle all outputs take their reset values and state is IDLE, regardless of `en` or phase.
- Reset values: `bclk`=0, `lrclk`=0, `bit_strobe`=0, `bclk_rise`=0, `frame_start`=0, `busy`=0, `bit_idx`=BITS-1, `ch_idx`=0, `cnt`=0.
- Restart after reset follows the IDLE→RUN rule. With `en` held high, `frame_start` appears one cycle after `rst` drops.

## Timing
- BCLK period = 2·HALF_DIV `clk` cycles, 50 % duty.
- Frame = BITS·CHANNELS BCLK periods.
- Fs = f_clk / (2·HALF_DIV·BITS·CHANNELS).
- Start latency: `en` sampled at edge T → first strobe at T+1 → first `bclk` rise at T+1+HALF_DIV.
- HALF_DIV=1: `bclk` toggles every cycle, and `bit_strobe`/`bclk_rise` alternate every cycle.
- `bit_idx`, `ch_idx` and `lrclk` are stable from one `bit_strobe` to the next.
- Serialisers drive data at `bit_strobe`; receivers sample at `bclk_rise`.
- All outputs are registered, with no combinational path from `en`.

## Test plan
- Defaults (HALF_DIV=2, BITS=24, CH=2, MODE=0), `en`=1 constant:
  - `bclk` period is 4 clk.
  - 48 `bit_strobe` per frame; `frame_start` every 192 clk.
  - `lrclk` rises on the strobe with ch 0 / `bit_idx`=0 and falls on ch 1 / `bit_idx`=0.
- MODE=1, same parameters: `lrclk` changes on the strobes with `bit_idx`=23; it is high exactly while `ch_idx`=1.
- `en` dropped at ch 1 / `bit_idx`=10:
  - The frame completes through ch 1 / bit 0.
  - At the next fall: `busy`=0, `bclk`=0, `lrclk`=0, no further strobes.
  - Repeat the run with `en` reasserted at ch 1 / bit 5: no gap, `frame_start` follows on schedule.
- `rst` pulsed for 1 cycle while `bclk`=1 mid-frame, `en` held high:
  - The next cycle shows all reset values.
  - `frame_start` appears the cycle after `rst` drops.
  - The first `bclk` rise follows HALF_DIV cycles later.
- HALF_DIV=1, BITS=16, CHANNELS=4, MODE=1:
  - `bclk` toggles every clk; frame = 128 clk.
  - `lrclk`=0 for `ch_idx` 0–1 (64 clk) and 1 for `ch_idx` 2–3.
  - `ch_idx` wraps 3→0 with `frame_start`.

Source files
------------

// File: rtl/i2s_clock_gen_if.sv
// Clock-generator output bundle: run request in, bit/frame clocks, strobes and
// slot position out. master = generator side, slave = consumer side.
interface i2s_clock_gen_if #(
   parameter int BITS     = 24,
   parameter int CHANNELS = 2
);
   localparam int BW = ($clog2(BITS) > 1) ? $clog2(BITS) : 1;
   localparam int CW = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;

   logic          en;
   logic          bclk;
   logic          lrclk;
   logic          bit_strobe;
   logic          bclk_rise;
   logic          frame_start;
   logic [BW-1:0] bit_idx;
   logic [CW-1:0] ch_idx;
   logic          busy;

   modport master (
      input  en,
      output bclk, lrclk, bit_strobe, bclk_rise, frame_start, bit_idx, ch_idx, busy
   );

   modport slave (
      output en,
      input  bclk, lrclk, bit_strobe, bclk_rise, frame_start, bit_idx, ch_idx, busy
   );
endinterface

// File: rtl/i2s_clock_gen.sv
// I2S / left-justified BCLK and LRCLK generator running entirely in clk.
// Consumers use bit_strobe (launch) and bclk_rise (sample) instead of bclk edges.
//
// state | meaning
// IDLE  | clocks parked low, no strobes; leaves on en=1
// RUN   | divider running; en=0 honoured only at the frame-boundary fall
module i2s_clock_gen #(
   parameter int HALF_DIV = 2,
   parameter int BITS     = 24,
   parameter int CHANNELS = 2,
   parameter int MODE     = 0
) (
   input logic               clk,
   input logic               rst,
   i2s_clock_gen_if.master   bus
);
   localparam int BW = ($clog2(BITS) > 1) ? $clog2(BITS) : 1;
   localparam int CW = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;
   localparam int DW = ($clog2(HALF_DIV) > 1) ? $clog2(HALF_DIV) : 1;

   localparam logic [BW-1:0] BIT_MSB  = BW'(BITS - 1);
   localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
   localparam logic [CW-1:0] CH_HALF  = CW'(CHANNELS / 2);
   localparam logic [DW-1:0] CNT_LAST = DW'(HALF_DIV - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_nx;
   logic [DW-1:0] cnt_q, cnt_nx;
   logic          bclk_q, bclk_nx;
   logic          lrclk_q, lrclk_nx;
   logic          strobe_q, strobe_nx;
   logic          rise_q, rise_nx;
   logic          fs_q, fs_nx;
   logic [BW-1:0] bit_q, bit_nx;
   logic [CW-1:0] ch_q, ch_nx;
   logic [CW-1:0] ch_inc;
   logic          frame_end;

   assign ch_inc    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
   assign frame_end = (bit_q == '0) && (ch_q == CH_LAST);

   // Register all state and outputs; reset parks everything at the idle values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bclk_q   <= 1'b0;
         lrclk_q  <= 1'b0;
         strobe_q <= 1'b0;
         rise_q   <= 1'b0;
         fs_q     <= 1'b0;
         bit_q    <= BIT_MSB;
         ch_q     <= '0;
      end else begin
         state_q  <= state_nx;
         cnt_q    <= cnt_nx;
         bclk_q   <= bclk_nx;
         lrclk_q  <= lrclk_nx;
         strobe_q <= strobe_nx;
         rise_q   <= rise_nx;
         fs_q     <= fs_nx;
         bit_q    <= bit_nx;
         ch_q     <= ch_nx;
      end
   end

   // Next state: divider, bclk edges, slot advance, LRCLK timing and stop handling.
   always_comb begin
      state_nx  = state_q;
      cnt_nx    = cnt_q;
      bclk_nx   = bclk_q;
      lrclk_nx  = lrclk_q;
      strobe_nx = 1'b0;
      rise_nx   = 1'b0;
      fs_nx     = 1'b0;
      bit_nx    = bit_q;
      ch_nx     = ch_q;
      case (state_q)
         IDLE: begin
            cnt_nx   = '0;
            bclk_nx  = 1'b0;
            lrclk_nx = 1'b0;
            bit_nx   = BIT_MSB;
            ch_nx    = '0;
            if (bus.en) begin
               state_nx  = RUN;
               strobe_nx = 1'b1;
               fs_nx     = 1'b1;
            end
         end
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               cnt_nx  = '0;
               bclk_nx = ~bclk_q;
               if (!bclk_q) begin
                  rise_nx = 1'b1;
               end else if (frame_end && !bus.en) begin
                  // Stop only on a frame boundary so the last frame is never truncated.
                  state_nx = IDLE;
                  bit_nx   = BIT_MSB;
                  ch_nx    = '0;
                  lrclk_nx = 1'b0;
               end else begin
                  strobe_nx = 1'b1;
                  fs_nx     = frame_end;
                  if (bit_q == '0) begin
                     bit_nx = BIT_MSB;
                     ch_nx  = ch_inc;
                  end else begin
                     bit_nx = bit_q - 1'b1;
                  end
                  // I2S moves word select one bit early, on the slot's LSB launch.
                  if (MODE == 1) begin
                     lrclk_nx = (ch_nx >= CH_HALF);
                  end else if (bit_nx == '0) begin
                     lrclk_nx = (ch_inc >= CH_HALF);
                  end
               end
            end else begin
               cnt_nx = cnt_q + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.bclk        = bclk_q;
   assign bus.lrclk       = lrclk_q;
   assign bus.bit_strobe  = strobe_q;
   assign bus.bclk_rise   = rise_q;
   assign bus.frame_start = fs_q;
   assign bus.bit_idx     = bit_q;
   assign bus.ch_idx      = ch_q;
   assign bus.busy        = (state_q == RUN);
endmodule

// File: tb/tb_i2s_clock_gen.sv
// Bench for i2s_clock_gen: three configurations sharing one clock; expected
// strobe sequences are queued per frame and popped as the DUT emits strobes.
module tb_i2s_clock_gen;
   logic clk = 1'b0;
   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_st = -1;
   int   last_fs = -1;
   logic [1:0] sel = 2'd0;

   typedef struct {int ch; int bi; bit lr; bit fs;} exp_t;
   exp_t sbq[$];

   i2s_clock_gen_if #(.BITS(24), .CHANNELS(2)) if_a ();
   i2s_clock_gen_if #(.BITS(24), .CHANNELS(2)) if_b ();
   i2s_clock_gen_if #(.BITS(16), .CHANNELS(4)) if_c ();

   i2s_clock_gen #(.HALF_DIV(2), .BITS(24), .CHANNELS(2), .MODE(0)) u_a (.clk(clk), .rst(rst_a), .bus(if_a));
   i2s_clock_gen #(.HALF_DIV(2), .BITS(24), .CHANNELS(2), .MODE(1)) u_b (.clk(clk), .rst(rst_b), .bus(if_b));
   i2s_clock_gen #(.HALF_DIV(1), .BITS(16), .CHANNELS(4), .MODE(1)) u_c (.clk(clk), .rst(rst_c), .bus(if_c));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        obs_bclk, obs_lr, obs_strobe, obs_rise, obs_fs, obs_busy;
   logic [31:0] obs_bit, obs_ch;

   always_comb begin
      obs_bclk = 1'b0; obs_lr = 1'b0; obs_strobe = 1'b0; obs_rise = 1'b0;
      obs_fs = 1'b0; obs_busy = 1'b0; obs_bit = '0; obs_ch = '0;
      case (sel)
         2'd0: begin
            obs_bclk = if_a.bclk; obs_lr = if_a.lrclk; obs_strobe = if_a.bit_strobe;
            obs_rise = if_a.bclk_rise; obs_fs = if_a.frame_start; obs_busy = if_a.busy;
            obs_bit = 32'(if_a.bit_idx); obs_ch = 32'(if_a.ch_idx);
         end
         2'd1: begin
            obs_bclk = if_b.bclk; obs_lr = if_b.lrclk; obs_strobe = if_b.bit_strobe;
            obs_rise = if_b.bclk_rise; obs_fs = if_b.frame_start; obs_busy = if_b.busy;
            obs_bit = 32'(if_b.bit_idx); obs_ch = 32'(if_b.ch_idx);
         end
         default: begin
            obs_bclk = if_c.bclk; obs_lr = if_c.lrclk; obs_strobe = if_c.bit_strobe;
            obs_rise = if_c.bclk_rise; obs_fs = if_c.frame_start; obs_busy = if_c.busy;
            obs_bit = 32'(if_c.bit_idx); obs_ch = 32'(if_c.ch_idx);
         end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic sb_reset();
      sbq.delete();
      last_st = -1;
      last_fs = -1;
   endtask

   // Expected strobe sequence straight from the framing rules.
   task automatic push_frames(input int bits, input int chs, input int mode, input int nf);
      exp_t e;
      for (int f = 0; f < nf; f++)
         for (int c = 0; c < chs; c++)
            for (int b = bits - 1; b >= 0; b--) begin
               e.ch = c;
               e.bi = b;
               if (mode == 1) e.lr = (c >= chs / 2);
               else if (b == 0) e.lr = (((c + 1) % chs) >= chs / 2);
               else e.lr = (c >= chs / 2);
               e.fs = (c == 0) && (b == bits - 1);
               sbq.push_back(e);
            end
   endtask

   task automatic consume(input int hd, input int per, input int first_at,
                          input int stop_after, input int budget);
      int   popped = 0;
      int   n = 0;
      exp_t e;
      while (sbq.size() > 0 && popped < stop_after && n < budget) begin
         @(negedge clk);
         n++;
         if (obs_rise) begin
            chk("rise_bclk", obs_bclk, 1);
            if (last_st >= 0) chk("rise_phase", cyc - last_st, hd);
         end
         if (obs_strobe) begin
            e = sbq.pop_front();
            popped++;
            if (first_at > 0 && popped == 1) chk("start_latency", n, first_at);
            else if (last_st >= 0) chk("bit_period", cyc - last_st, 2 * hd);
            chk("bclk_at_strobe", obs_bclk, 0);
            chk("ch_idx", obs_ch, e.ch);
            chk("bit_idx", obs_bit, e.bi);
            chk("lrclk", obs_lr, e.lr);
            chk("frame_start", obs_fs, e.fs);
            if (obs_fs) begin
               if (last_fs >= 0) chk("frame_period", cyc - last_fs, per);
               last_fs = cyc;
            end
            last_st = cyc;
         end else begin
            chk("fs_without_strobe", obs_fs, 0);
         end
      end
      if (n >= budget && sbq.size() > 0 && popped < stop_after) chk("sb_timeout", sbq.size(), 0);
   endtask

   task automatic chk_reset_vals(input string tag, input int msb);
      chk({tag, "_bclk"}, obs_bclk, 0);
      chk({tag, "_lrclk"}, obs_lr, 0);
      chk({tag, "_strobe"}, obs_strobe, 0);
      chk({tag, "_rise"}, obs_rise, 0);
      chk({tag, "_fs"}, obs_fs, 0);
      chk({tag, "_busy"}, obs_busy, 0);
      chk({tag, "_bit"}, obs_bit, msb);
      chk({tag, "_ch"}, obs_ch, 0);
   endtask

   initial begin
      int k;
      int strobes;
      if_a.en = 1'b0;
      if_b.en = 1'b0;
      if_c.en = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state and idle behaviour of the default configuration.
      sel = 2'd0;
      chk_reset_vals("reset", 23);
      rst_a = 1'b0;
      @(negedge clk);
      chk("idle_busy", obs_busy, 0);
      chk("idle_strobe", obs_strobe, 0);

      // Two continuous I2S frames.
      push_frames(24, 2, 0, 2);
      if_a.en = 1'b1;
      consume(2, 192, 1, 9999, 1000);

      // Drop en at ch1/bit10: frame completes, stop at the boundary fall.
      push_frames(24, 2, 0, 1);
      consume(2, 192, 0, 38, 400);
      if_a.en = 1'b0;
      consume(2, 192, 0, 9999, 100);
      repeat (3) @(negedge clk);
      chk("stop_busy_before", obs_busy, 1);
      chk("stop_bclk_before", obs_bclk, 1);
      @(negedge clk);
      chk_reset_vals("stop", 23);
      strobes = 0;
      repeat (30) begin
         @(negedge clk);
         if (obs_strobe) strobes++;
      end
      chk("stop_no_strobes", strobes, 0);

      // Restart; en glitches low between ch1/bit10 and ch1/bit5 without effect.
      sb_reset();
      push_frames(24, 2, 0, 2);
      if_a.en = 1'b1;
      consume(2, 192, 1, 38, 400);
      if_a.en = 1'b0;
      consume(2, 192, 0, 5, 100);
      if_a.en = 1'b1;
      consume(2, 192, 0, 9999, 600);

      // One-cycle reset while bclk is high mid-frame, en held high.
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!obs_bclk && k < 10);
      chk("find_bclk_high", obs_bclk, 1);
      rst_a = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst", 23);
      rst_a = 1'b0;
      @(negedge clk);
      chk("rst_fs", obs_fs, 1);
      chk("rst_strobe", obs_strobe, 1);
      chk("rst_busy", obs_busy, 1);
      chk("rst_bit", obs_bit, 23);
      chk("rst_ch", obs_ch, 0);
      chk("rst_bclk", obs_bclk, 0);
      @(negedge clk);
      chk("rst_bclk_hold", obs_bclk, 0);
      chk("rst_no_rise", obs_rise, 0);
      @(negedge clk);
      chk("rst_first_rise", obs_rise, 1);
      chk("rst_first_bclk", obs_bclk, 1);
      if_a.en = 1'b0;
      rst_a = 1'b1;

      // Left-justified, same geometry.
      sel = 2'd1;
      sb_reset();
      push_frames(24, 2, 1, 2);
      rst_b = 1'b0;
      if_b.en = 1'b1;
      consume(2, 192, 1, 9999, 1000);
      if_b.en = 1'b0;
      rst_b = 1'b1;

      // HALF_DIV=1, 16-bit slots, 4 channels, left-justified.
      sel = 2'd2;
      sb_reset();
      push_frames(16, 4, 1, 2);
      rst_c = 1'b0;
      if_c.en = 1'b1;
      consume(1, 128, 1, 9999, 400);
      if_c.en = 1'b0;
      rst_c = 1'b1;

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
